// File: rtl/apb_regfile_ws.sv
// apb_regfile_ws: APB slave CSR block with RW control regs, RO status words and wait states
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   psel, penable, pwrite    APB control
//   paddr, pwdata, pstrb     APB address, write data, byte strobes
//   prdata, pready, pslverr  APB response
//   rw_regs_o                flat RW register contents, reg i at [i*DATA_W +: DATA_W]
//   wr_pulse_o               one-cycle pulse per RW register written
//   ro_status_i              flat status words, word j at [j*DATA_W +: DATA_W]
module apb_regfile_ws #(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 8,
   parameter int                NUM_RW      = 4,
   parameter int                NUM_RO      = 2,
   parameter int                WAIT_STATES = 0,
   parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       psel,
   input  logic                       penable,
   input  logic                       pwrite,
   input  logic [ADDR_W-1:0]          paddr,
   input  logic [DATA_W-1:0]          pwdata,
   input  logic [DATA_W/8-1:0]        pstrb,
   output logic [DATA_W-1:0]          prdata,
   output logic                       pready,
   output logic                       pslverr,
   output logic [NUM_RW*DATA_W-1:0]   rw_regs_o,
   output logic [NUM_RW-1:0]          wr_pulse_o,
   input  logic [NUM_RO*DATA_W-1:0]   ro_status_i
);
   localparam int             NB    = DATA_W / 8;
   localparam int             IW    = ADDR_W - 2;
   localparam logic [3:0]     WS    = 4'(WAIT_STATES);
   localparam logic [IW:0]    RW_N  = (IW+1)'(NUM_RW);
   localparam logic [IW:0]    TOT_N = (IW+1)'(NUM_RW + NUM_RO);

   if (NUM_RW + NUM_RO > (1 << IW)) begin : g_bad_map
      $error("apb_regfile_ws: NUM_RW+NUM_RO exceeds the address space");
   end
   if (DATA_W % 8 != 0 || WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_cfg
      $error("apb_regfile_ws: DATA_W must be a multiple of 8 and WAIT_STATES in 0..15");
   end

   logic [3:0]               cnt_q, cnt_d;
   logic [NUM_RW*DATA_W-1:0] regs_q, regs_d;
   logic [NUM_RW-1:0]        pulse_q, pulse_d;
   logic [IW:0]              idx;
   logic [DATA_W-1:0]        rd, mask;
   logic                     access, done, rw_hit, ro_hit, we;
   logic                     unused_addr;

   assign unused_addr = ^paddr[1:0];
   assign idx         = {1'b0, paddr[ADDR_W-1:2]};
   assign access      = psel & penable;
   assign done        = access & (cnt_q == WS);
   // Bus response is held quiet for the whole time reset is asserted.
   assign pready      = ~rst & done;
   assign rw_hit      = idx < RW_N;
   assign ro_hit      = ~rw_hit & (idx < TOT_N);
   assign we          = pready & pwrite & rw_hit;
   assign prdata      = (pready & ~pwrite) ? rd : '0;
   assign pslverr     = pready & (pwrite ? ~rw_hit : ~(rw_hit | ro_hit));
   assign rw_regs_o   = regs_q;
   assign wr_pulse_o  = pulse_q;
   assign cnt_d       = (~access | done) ? 4'd0 : cnt_q + 4'd1;

   always_comb begin
      rd = '0;
      for (int i = 0; i < NUM_RW; i++)
         if (idx == (IW+1)'(i)) rd = regs_q[i*DATA_W +: DATA_W];
      for (int j = 0; j < NUM_RO; j++)
         if (idx == (IW+1)'(NUM_RW + j)) rd = ro_status_i[j*DATA_W +: DATA_W];
   end

   always_comb begin
      mask = '0;
      for (int b = 0; b < NB; b++) mask[b*8 +: 8] = {8{pstrb[b]}};
   end

   // A committed write pulses its register even with no strobes set.
   always_comb begin
      regs_d  = regs_q;
      pulse_d = '0;
      for (int i = 0; i < NUM_RW; i++)
         if (we && idx == (IW+1)'(i)) begin
            pulse_d[i]                 = 1'b1;
            regs_d[i*DATA_W +: DATA_W] = (regs_q[i*DATA_W +: DATA_W] & ~mask) | (pwdata & mask);
         end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         regs_q  <= {NUM_RW{RESET_VAL}};
         pulse_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         regs_q  <= regs_d;
         pulse_q <= pulse_d;
      end
   end
endmodule

// File: doc/apb_regfile_ws.md
Name: apb_regfile_ws

Overview:
Parametrised APB slave register file for peripheral control/status space. It provides NUM_RW read/write control registers and NUM_RO read-only status words, with byte strobes, error response and a programmable number of wait states. Each RW register drives a flat output bus and raises a one-cycle write pulse when written. Intended as the standard CSR block behind the APB interconnect.

Parameters:
DATA_W, 32, data width in bits; multiple of 8.
ADDR_W, 8, APB address width; word index = paddr[ADDR_W-1:2].
NUM_RW, 4, number of RW registers, indices 0..NUM_RW-1.
NUM_RO, 2, number of RO status words, indices NUM_RW..NUM_RW+NUM_RO-1.
WAIT_STATES, 0, pready-low cycles inserted in each access phase (0..15).
RESET_VAL, 0, reset value of every RW register.
Constraint: NUM_RW+NUM_RO <= 2^(ADDR_W-2); elaboration error otherwise.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
psel  input  1  APB select.
penable  input  1  APB enable (access phase).
pwrite  input  1  1 = write, 0 = read.
paddr  input  ADDR_W  byte address; bits [1:0] ignored.
pwdata  input  DATA_W  write data.
pstrb  input  DATA_W/8  write byte strobes.
prdata  output  DATA_W  read data.
pready  output  1  transfer complete.
pslverr  output  1  error response, valid with pready.
rw_regs_o  output  NUM_RW*DATA_W  RW register contents; reg i at [i*DATA_W +: DATA_W].
wr_pulse_o  output  NUM_RW  one-cycle pulse per RW register written.
ro_status_i  input  NUM_RO*DATA_W  status words; word j at [j*DATA_W +: DATA_W].

Behaviour:
- Reset (rst=1 at posedge): RW regs = RESET_VAL, wait counter = 0, wr_pulse_o = 0. While rst=1: pready = 0, pslverr = 0, prdata = 0.
- Reset mid-transfer: counter clears and no write commits. The transfer completes normally after rst deasserts and WAIT_STATES further cycles elapse.
- Access = psel & penable.
- Wait counter cnt (4 bits):
  - Increments each access cycle while cnt != WAIT_STATES.
  - Clears to 0 in the completion cycle and whenever access = 0.
- pready = access & (cnt == WAIT_STATES), combinational from registered cnt. WAIT_STATES=0 gives zero-wait transfers (pready=1 in the first access cycle). WAIT_STATES=N gives N cycles of pready=0 first.
- Decode: idx = paddr[ADDR_W-1:2].
  - RW hit: idx < NUM_RW.
  - RO hit: NUM_RW <= idx < NUM_RW+NUM_RO.
  - Anything else is a miss.
- Completion cycle (pready=1):
  - Write, RW hit: at the clock edge ending this cycle, each byte b with pstrb[b]=1 updates from pwdata; other bytes hold. wr_pulse_o[idx] = 1 for exactly the following cycle, including when pstrb = 0. pslverr = 0.
  - Write, RO hit or miss: no state change, no pulse, pslverr = 1.
  - Read, RW hit: prdata = register value (pre-write value, since no write can coincide). pslverr = 0.
  - Read, RO hit: prdata = ro_status_i word (idx-NUM_RW), sampled combinationally in the completion cycle. pslverr = 0.
  - Read miss: prdata = 0, pslverr = 1.
- Outside completion cycles: prdata = 0, pslverr = 0.
- rw_regs_o is driven directly from the registers; updates are visible the cycle after commit.
- Setup phase (psel=1, penable=0): no effect on any state.

Test Plan:
- Reset: assert rst 2 cycles with RESET_VAL=0xA5A5A5A5 -> all rw_regs_o words = 0xA5A5A5A5, wr_pulse_o=0, pready=0.
- Zero-wait write/read: write 0x12345678, pstrb=0xF to 0x04 -> pready=1 in first access cycle; next cycle reg1=0x12345678 and wr_pulse_o=4'b0010 for exactly 1 cycle. Read 0x04 -> prdata=0x12345678, pslverr=0.
- Byte strobes: reg0=0x11223344, write 0xAABBCCDD with pstrb=4'b0101 -> reg0=0x11BB33DD.
- Wait states: WAIT_STATES=3, read 0x10 with ro_status_i word0=0xDEADBEEF -> pready low 3 access cycles, high on the 4th with prdata=0xDEADBEEF; prdata=0 before completion.
- Errors: write 0x10 (RO) -> pslverr=1, no pulse, regs unchanged. Read 0x20 (miss) -> prdata=0, pslverr=1.
- Reset mid-wait: WAIT_STATES=3, write to 0x00 and pulse rst in the 2nd access cycle -> reg0 stays RESET_VAL, no pulse. With psel/penable still high, completion occurs 3 cycles after rst release and commits the write.
